// File: rtl/flee_rx_monitor.sv
// Sink monitor for one flee port: accepts flits, tracks packet framing, flags errors and stalls.
// Latency: the log port (flit_o/flit_vld_o/pkt_done_o/pkt_len_o/counters) updates 1 cycle after acceptance.
// Backpressure: ready_o is registered; with FLEE_RX_BP_EN defined it follows a periodic stall pattern, otherwise it is 1 after reset.
module flee_rx_monitor #(
  parameter int DW        = 32,
  parameter int BP_PERIOD = 16,
  parameter int BP_STALL  = 0,
  parameter int WD_LIMIT  = 10000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] data_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic          clr_i,
  output logic [DW-1:0] flit_o,
  output logic          flit_vld_o,
  output logic          pkt_done_o,
  output logic [15:0]   pkt_len_o,
  output logic [31:0]   flit_cnt_o,
  output logic [31:0]   pkt_cnt_o,
  output logic          proto_err_o,
  output logic          deadlock_o
);

  localparam int WDW = $clog2(WD_LIMIT + 1);

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef enum logic {ST_IDLE, ST_IN_PKT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_ready;
  logic [DW-1:0]   r_flit;
  logic            r_flit_vld;
  logic            r_pkt_done;
  logic [15:0]     r_pkt_len;
  logic [15:0]     r_len;
  logic [31:0]     r_flit_cnt;
  logic [31:0]     r_pkt_cnt;
  logic            r_proto_err;
  logic            r_deadlock;
  logic [WDW-1:0]  r_wd_cnt;

  logic            w_acc;
  logic [1:0]      w_type;
  logic [15:0]     w_len_inc;
  logic [15:0]     w_len_nxt;
  logic            w_done;
  logic [15:0]     w_done_len;
  logic            w_err;
  logic [31:0]     w_flit_base;
  logic [31:0]     w_pkt_base;
  logic [WDW-1:0]  w_wd_base;
  logic            w_wd_hit;

  assign w_acc     = valid_i & r_ready;
  assign w_type    = data_i[DW-1:DW-2];
  assign w_len_inc = (r_len == 16'hFFFF) ? r_len : r_len + 16'd1;

`ifdef FLEE_RX_BP_EN
  localparam int BPW = (BP_PERIOD > 2) ? $clog2(BP_PERIOD) : 1;

  logic [BPW-1:0] r_bp_cnt;
  logic [BPW-1:0] w_bp_nxt;

  assign w_bp_nxt = (r_bp_cnt == BPW'(BP_PERIOD - 1)) ? '0 : r_bp_cnt + BPW'(1);

  // Periodic back-pressure: ready drops for the first BP_STALL slots of each period
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_bp_cnt <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_bp_cnt <= w_bp_nxt;
      r_ready  <= (int'(w_bp_nxt) >= BP_STALL);
    end
  end
`else
  // No back-pressure: ready is held low in reset only
  always_ff @(posedge clk) begin
    if (!rstn) r_ready <= 1'b0;
    else       r_ready <= 1'b1;
  end
`endif

  // Framing FSM state register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Framing FSM next-state decode on accepted flits
  always_comb begin
    w_state_nxt = r_state;
    if (w_acc) begin
      case (r_state)
        ST_IDLE:   if (w_type == T_HEAD) w_state_nxt = ST_IN_PKT;
        ST_IN_PKT: if (w_type == T_TAIL || w_type == T_SINGLE) w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Framing FSM outputs: packet completion, length tracking and protocol errors
  always_comb begin
    w_done     = 1'b0;
    w_done_len = 16'd0;
    w_err      = 1'b0;
    w_len_nxt  = r_len;
    if (w_acc) begin
      case (r_state)
        ST_IDLE: begin
          case (w_type)
            T_HEAD:   w_len_nxt = 16'd1;
            T_SINGLE: begin
              w_done     = 1'b1;
              w_done_len = 16'd1;
            end
            default:  w_err = 1'b1;
          endcase
        end
        ST_IN_PKT: begin
          case (w_type)
            T_BODY:   w_len_nxt = w_len_inc;
            T_TAIL: begin
              w_done     = 1'b1;
              w_done_len = w_len_inc;
              w_len_nxt  = 16'd0;
            end
            T_HEAD: begin
              // The open packet is dropped and the new head restarts the count
              w_err     = 1'b1;
              w_len_nxt = 16'd1;
            end
            default: begin
              // Open packet dropped; the single still counts as a complete packet
              w_err      = 1'b1;
              w_done     = 1'b1;
              w_done_len = 16'd1;
              w_len_nxt  = 16'd0;
            end
          endcase
        end
        default: w_len_nxt = 16'd0;
      endcase
    end
  end

  // Clear is applied first so a same-cycle event lands on the cleared value
  assign w_flit_base = clr_i ? 32'd0 : r_flit_cnt;
  assign w_pkt_base  = clr_i ? 32'd0 : r_pkt_cnt;
  assign w_wd_base   = clr_i ? '0 : r_wd_cnt;
  assign w_wd_hit    = (r_state == ST_IN_PKT) && !w_acc && ((int'(w_wd_base) + 1) >= WD_LIMIT);

  // Log port, packet length and statistics counters
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_flit      <= '0;
      r_flit_vld  <= 1'b0;
      r_pkt_done  <= 1'b0;
      r_pkt_len   <= 16'd0;
      r_len       <= 16'd0;
      r_flit_cnt  <= 32'd0;
      r_pkt_cnt   <= 32'd0;
      r_proto_err <= 1'b0;
      r_deadlock  <= 1'b0;
    end else begin
      r_flit_vld <= w_acc;
      if (w_acc) r_flit <= data_i;
      r_pkt_done <= w_done;
      if (w_done) r_pkt_len <= w_done_len;
      r_len       <= w_len_nxt;
      r_flit_cnt  <= (w_acc && (w_flit_base != 32'hFFFF_FFFF)) ? w_flit_base + 32'd1 : w_flit_base;
      r_pkt_cnt   <= (w_done && (w_pkt_base != 32'hFFFF_FFFF)) ? w_pkt_base + 32'd1 : w_pkt_base;
      r_proto_err <= (r_proto_err & ~clr_i) | w_err;
      r_deadlock  <= (r_deadlock & ~clr_i) | w_wd_hit;
    end
  end

  // Deadlock watchdog: counts non-accepting cycles inside a packet, holds once the limit is hit
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wd_cnt <= '0;
    end else if ((r_state == ST_IN_PKT) && !w_acc) begin
      if (w_wd_hit) r_wd_cnt <= w_wd_base;
      else          r_wd_cnt <= w_wd_base + WDW'(1);
    end else begin
      r_wd_cnt <= '0;
    end
  end

  assign ready_o     = r_ready;
  assign flit_o      = r_flit;
  assign flit_vld_o  = r_flit_vld;
  assign pkt_done_o  = r_pkt_done;
  assign pkt_len_o   = r_pkt_len;
  assign flit_cnt_o  = r_flit_cnt;
  assign pkt_cnt_o   = r_pkt_cnt;
  assign proto_err_o = r_proto_err;
  assign deadlock_o  = r_deadlock;

endmodule

// File: tb/tb_flee_rx_monitor.sv
// Directed bench for flee_rx_monitor: vector table for framing/counters/watchdog/clear,
// plus hand sequences for reset mid-packet and (when FLEE_RX_BP_EN is defined) the back-pressure pattern.
module tb_flee_rx_monitor;

  localparam int DW = 16;
  localparam logic [1:0] B = 2'b00, H = 2'b01, T = 2'b10, S = 2'b11;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic          clr_i;
  logic [DW-1:0] flit_o;
  logic          flit_vld_o;
  logic          pkt_done_o;
  logic [15:0]   pkt_len_o;
  logic [31:0]   flit_cnt_o;
  logic [31:0]   pkt_cnt_o;
  logic          proto_err_o;
  logic          deadlock_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  flee_rx_monitor #(.DW(DW), .BP_PERIOD(4), .BP_STALL(1), .WD_LIMIT(8)) dut (
    .clk(clk), .rstn(rstn), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .clr_i(clr_i), .flit_o(flit_o), .flit_vld_o(flit_vld_o), .pkt_done_o(pkt_done_o),
    .pkt_len_o(pkt_len_o), .flit_cnt_o(flit_cnt_o), .pkt_cnt_o(pkt_cnt_o),
    .proto_err_o(proto_err_o), .deadlock_o(deadlock_o)
  );

  typedef struct {
    logic        v;
    logic [1:0]  t;
    logic        c;
    logic        e_vld;
    logic        e_done;
    logic [15:0] e_len;
    logic [31:0] e_fc;
    logic [31:0] e_pc;
    logic        e_err;
    logic        e_dl;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [1:0] t, input logic c, input logic vld,
                     input logic done, input logic [15:0] len, input logic [31:0] fc,
                     input logic [31:0] pc, input logic err, input logic dl);
    vec_t r;
    r.v = v; r.t = t; r.c = c; r.e_vld = vld; r.e_done = done; r.e_len = len;
    r.e_fc = fc; r.e_pc = pc; r.e_err = err; r.e_dl = dl;
    tbl.push_back(r);
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic c);
    valid_i = v; data_i = d; clr_i = c;
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ready"}, 32'(ready_o), 32'd0);
    chk({tag, " flit"}, 32'(flit_o), 32'd0);
    chk({tag, " vld"}, 32'(flit_vld_o), 32'd0);
    chk({tag, " done"}, 32'(pkt_done_o), 32'd0);
    chk({tag, " len"}, 32'(pkt_len_o), 32'd0);
    chk({tag, " fcnt"}, flit_cnt_o, 32'd0);
    chk({tag, " pcnt"}, pkt_cnt_o, 32'd0);
    chk({tag, " err"}, 32'(proto_err_o), 32'd0);
    chk({tag, " dl"}, 32'(deadlock_o), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] last_flit;
    int nacc;
    last_flit = '0;
    rstn = 1'b0; valid_i = 1'b0; clr_i = 1'b0; data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rstn = 1'b1;

`ifdef FLEE_RX_BP_EN
    // Continuous singles under BP_PERIOD=4 / BP_STALL=1: ready 0111..., 30 of 40 accepted
    nacc = 0;
    for (int j = 1; j <= 40; j++) begin
      step(1'b1, {S, 14'h0}, 1'b0);
      chk($sformatf("bp ready e%0d", j), 32'(ready_o), (j % 4 != 0) ? 32'd1 : 32'd0);
      if (flit_vld_o) nacc++;
    end
    chk("bp accepts", 32'(nacc), 32'd30);
    chk("bp pkt_cnt", pkt_cnt_o, 32'd30);
    chk("bp flit_cnt", flit_cnt_o, 32'd30);
`else
    //   v     t  c  vld done len fc  pc  err dl
    add(1'b0, B, 0, 0, 0, 0, 0, 0, 0, 0);              // first edge after release: ready rises
    for (int p = 0; p < 3; p++) begin                   // three 4-flit packets back-to-back
      add(1'b1, H, 0, 1, 0, 0, 32'(4*p+1), 32'(p), 0, 0);
      add(1'b1, B, 0, 1, 0, 0, 32'(4*p+2), 32'(p), 0, 0);
      add(1'b1, B, 0, 1, 0, 0, 32'(4*p+3), 32'(p), 0, 0);
      add(1'b1, T, 0, 1, 1, 4, 32'(4*p+4), 32'(p+1), 0, 0);
    end
    add(1'b0, B, 0, 0, 0, 0, 12, 3, 0, 0);              // idle: flit_o holds
    add(1'b0, B, 1, 0, 0, 0, 0, 0, 0, 0);               // clear alone
    add(1'b1, B, 0, 1, 0, 0, 1, 0, 1, 0);               // body in IDLE -> error
    add(1'b1, H, 0, 1, 0, 0, 2, 0, 1, 0);
    add(1'b1, B, 0, 1, 0, 0, 3, 0, 1, 0);
    add(1'b1, H, 0, 1, 0, 0, 4, 0, 1, 0);               // head in packet: discard, restart
    add(1'b1, T, 0, 1, 1, 2, 5, 1, 1, 0);               // only the second packet counts
    add(1'b1, H, 0, 1, 0, 0, 6, 1, 1, 0);               // watchdog: head then 8 idle edges
    for (int k = 1; k <= 7; k++) add(1'b0, B, 0, 0, 0, 0, 6, 1, 1, 0);
    add(1'b0, B, 0, 0, 0, 0, 6, 1, 1, 1);               // 8th idle edge -> deadlock
    add(1'b1, T, 0, 1, 1, 2, 7, 2, 1, 1);               // packet still completes
    add(1'b0, B, 0, 0, 0, 0, 7, 2, 1, 1);               // deadlock sticky
    add(1'b1, S, 1, 1, 1, 1, 1, 1, 0, 0);               // clear + single same cycle
    add(1'b1, B, 1, 1, 0, 0, 1, 0, 1, 0);               // clear + error same cycle
    add(1'b1, H, 0, 1, 0, 0, 2, 0, 1, 0);
    add(1'b0, B, 1, 0, 0, 0, 0, 0, 0, 0);               // clear does not disturb open packet
    add(1'b1, T, 0, 1, 1, 2, 1, 1, 0, 0);
    add(1'b1, H, 0, 1, 0, 0, 2, 1, 0, 0);
    add(1'b1, S, 0, 1, 1, 1, 3, 2, 1, 0);               // single in packet: error, counted

    for (int i = 0; i < tbl.size(); i++) begin
      d = {tbl[i].t, 6'b0, 8'(i)};
      step(tbl[i].v, d, tbl[i].c);
      if (tbl[i].e_vld) last_flit = d;
      chk($sformatf("row%0d ready", i), 32'(ready_o), 32'd1);
      chk($sformatf("row%0d vld", i), 32'(flit_vld_o), 32'(tbl[i].e_vld));
      chk($sformatf("row%0d flit", i), 32'(flit_o), 32'(last_flit));
      chk($sformatf("row%0d done", i), 32'(pkt_done_o), 32'(tbl[i].e_done));
      if (tbl[i].e_done) chk($sformatf("row%0d len", i), 32'(pkt_len_o), 32'(tbl[i].e_len));
      chk($sformatf("row%0d fcnt", i), flit_cnt_o, tbl[i].e_fc);
      chk($sformatf("row%0d pcnt", i), pkt_cnt_o, tbl[i].e_pc);
      chk($sformatf("row%0d err", i), 32'(proto_err_o), 32'(tbl[i].e_err));
      chk($sformatf("row%0d dl", i), 32'(deadlock_o), 32'(tbl[i].e_dl));
    end

    // Reset mid-packet abandons the packet; a later tail is a framing error
    step(1'b1, {H, 14'h11}, 1'b0);
    step(1'b1, {B, 14'h12}, 1'b0);
    rstn = 1'b0;
    step(1'b0, '0, 1'b0);
    chk_all_zero("midrst");
    rstn = 1'b1;
    step(1'b1, {T, 14'h13}, 1'b0);
    chk("midrst ready", 32'(ready_o), 32'd1);
    chk("midrst vld0", 32'(flit_vld_o), 32'd0);
    step(1'b1, {T, 14'h13}, 1'b0);
    chk("midrst vld1", 32'(flit_vld_o), 32'd1);
    chk("midrst err", 32'(proto_err_o), 32'd1);
    chk("midrst done", 32'(pkt_done_o), 32'd0);
    chk("midrst fcnt", flit_cnt_o, 32'd1);
    chk("midrst pcnt", pkt_cnt_o, 32'd0);
    step(1'b0, '0, 1'b0);
    chk("midrst done2", 32'(pkt_done_o), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
